// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encodings and defaults for the pipeline sequencer
package mips_pkg;

  localparam int NB_STATE         = 3;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_GO   = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALTED    = 3'd5
  } seq_state_t;

  // States in which a newly fetched instruction may enter the pipe
  function automatic logic is_fetching(input seq_state_t s);
    return (s == S_RUN) || (s == S_STEP_GO);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and branch-operand hazard detection
module hazard_detect #(
  parameter int NB_REG = 5
) (
  input  logic [NB_REG-1:0] i_ifid_rs,
  input  logic [NB_REG-1:0] i_ifid_rt,
  input  logic [NB_REG-1:0] i_idex_wreg,
  input  logic              i_idex_memRead,
  input  logic              i_idex_regWrite,
  input  logic              i_id_branch,
  output logic              o_stall
);

  logic w_wreg_nz;
  logic w_src_hit;
  logic w_load_use;
  logic w_branch_hz;

  // Register $0 is hardwired to zero, so a write to it never creates a dependency
  assign w_wreg_nz   = |i_idex_wreg;
  assign w_src_hit   = (i_idex_wreg == i_ifid_rs) || (i_idex_wreg == i_ifid_rt);

  // Loaded value is not available until after MEM; ID consumer must wait one cycle
  assign w_load_use  = i_idex_memRead & w_wreg_nz & w_src_hit;

  // Branches compare in ID, so any pending EX result they read forces a wait
  assign w_branch_hz = i_id_branch & i_idex_regWrite & w_wreg_nz & w_src_hit;

  assign o_stall     = w_load_use | w_branch_hz;

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - run/step/drain sequencer and hazard gating for a 5-stage pipe
module pipeline_sequencer
  import mips_pkg::*;
#(
  parameter int NB_REG       = 5,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_halt_id,
  input  logic              i_id_branch,
  input  logic              i_take_jump,
  input  logic [NB_REG-1:0] i_ifid_rs,
  input  logic [NB_REG-1:0] i_ifid_rt,
  input  logic              i_idex_memRead,
  input  logic              i_idex_regWrite,
  input  logic [NB_REG-1:0] i_idex_wreg,
  output logic              o_pipe_en,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_halted,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_cnt
);

  localparam int NB_DRN = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [NB_DRN-1:0] DRAIN_INIT = NB_DRN'(DRAIN_CYCLES);
  localparam logic [NB_DRN-1:0] DRAIN_LAST = NB_DRN'(1);

  seq_state_t        r_state;
  logic              r_step_mode;
  logic              r_pipe_en;
  logic              r_halted;
  logic [NB_DRN-1:0] r_drain_cnt;
  logic [NB_CNT-1:0] r_cycle_cnt;

  logic w_stall;
  logic w_fetching;
  logic w_draining;
  logic w_halt_take;

  hazard_detect #(
    .NB_REG (NB_REG)
  ) u_hazard_detect (
    .i_ifid_rs       (i_ifid_rs),
    .i_ifid_rt       (i_ifid_rt),
    .i_idex_wreg     (i_idex_wreg),
    .i_idex_memRead  (i_idex_memRead),
    .i_idex_regWrite (i_idex_regWrite),
    .i_id_branch     (i_id_branch),
    .o_stall         (w_stall)
  );

  assign w_fetching  = is_fetching(r_state);
  assign w_draining  = (r_state == S_DRAIN);
  // A stall holds the HALT in ID, so it is only honoured on a clean advance
  assign w_halt_take = w_fetching & r_pipe_en & i_halt_id & ~w_stall;

  // Sequencer FSM with registered advance enable, drain and cycle counters
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_step_mode <= 1'b0;
      r_pipe_en   <= 1'b0;
      r_halted    <= 1'b0;
      r_drain_cnt <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (r_pipe_en && (r_cycle_cnt != {NB_CNT{1'b1}})) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE, S_HALTED: begin
          if (i_start) begin
            r_cycle_cnt <= '0;
            r_step_mode <= i_step_mode;
            r_halted    <= 1'b0;
            if (i_step_mode) begin
              r_state   <= S_STEP_WAIT;
              r_pipe_en <= 1'b0;
            end else begin
              r_state   <= S_RUN;
              r_pipe_en <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (w_halt_take) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_INIT;
            r_pipe_en   <= 1'b1;
          end
        end

        S_STEP_WAIT: begin
          if (i_step) begin
            r_state   <= S_STEP_GO;
            r_pipe_en <= 1'b1;
          end
        end

        S_STEP_GO: begin
          r_pipe_en <= 1'b0;
          if (w_halt_take) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_INIT;
          end else begin
            r_state     <= S_STEP_WAIT;
          end
        end

        S_DRAIN: begin
          // Only advancing cycles retire a stage; in step mode each needs its own i_step
          if (r_pipe_en) begin
            if (r_drain_cnt <= DRAIN_LAST) begin
              r_state     <= S_HALTED;
              r_drain_cnt <= '0;
              r_pipe_en   <= 1'b0;
              r_halted    <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt - 1'b1;
              r_pipe_en   <= ~r_step_mode;
            end
          end else if (r_step_mode && i_step) begin
            r_pipe_en <= 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_pipe_en <= 1'b0;
        end
      endcase
    end
  end

  // Hazard-driven enables are combinational and forced low whenever the pipe is frozen
  always_comb begin
    o_idex_bubble = r_pipe_en & w_stall;
    o_ifid_flush  = r_pipe_en & ~w_stall & (i_take_jump | (w_fetching & i_halt_id));
    o_ifid_en     = r_pipe_en & ~w_stall & ~w_draining;
    o_pc_en       = r_pipe_en & ~w_stall & ~w_draining & ~(w_fetching & i_halt_id);
  end

  assign o_pipe_en   = r_pipe_en;
  assign o_halted    = r_halted;
  assign o_state     = r_state;
  assign o_cycle_cnt = r_cycle_cnt;

endmodule
